// File: rtl/adc_readout_pkg.sv
// Shared constants for the ADC fill readout path: word/lane geometry,
// header field positions and the reader FSM state encoding.
package adc_readout_pkg;

    localparam int LANE_W     = 32;
    localparam int DW         = 128;
    localparam int LANES      = DW / LANE_W;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    localparam int FILL_NUM_LSB = 0;
    localparam int FILL_NUM_W   = 24;
    localparam int BURSTS_LSB   = 24;
    localparam int BURSTS_W     = 21;
    localparam int BSA_LSB      = 45;
    localparam int BSA_W        = 23;
    localparam int TYPE_LSB     = 68;
    localparam int TYPE_W       = 2;
    localparam int TAG_LSB      = 70;
    localparam int TAG_W        = 16;
    localparam int RSVD_W       = DW - (TAG_LSB + TAG_W);

    localparam int CNT_W = 16;

    // Header word as it sits in the FIFO, MSB first.
    typedef struct packed {
        logic [RSVD_W-1:0]     rsvd;
        logic [TAG_W-1:0]      channel_tag;
        logic [TYPE_W-1:0]     fill_type;
        logic [BSA_W-1:0]      burst_start_adr;
        logic [BURSTS_W-1:0]   num_bursts;
        logic [FILL_NUM_W-1:0] fill_num;
    } fill_hdr_t;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_HDR   = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA  = 3'd2;
    localparam logic [ST_W-1:0] ST_CSUM  = 3'd3;
    localparam logic [ST_W-1:0] ST_ABORT = 3'd4;

endpackage

// File: rtl/adc_fill_reader_if.sv
// FIFO read port plus outgoing lane stream of the fill reader.
interface adc_fill_reader_if;
    import adc_readout_pkg::*;

    logic [DW-1:0]     fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [LANE_W-1:0] out_dat;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  fifo_dout, fifo_empty, out_ready,
        output fifo_rd_en, out_dat, out_valid, out_last
    );

    modport slave (
        output fifo_dout, fifo_empty, out_ready,
        input  fifo_rd_en, out_dat, out_valid, out_last
    );

endinterface

// File: rtl/adc_word_serializer.sv
// Presents one FIFO word as LANES consecutive LANE_W lanes, lane 0 first,
// advancing only on an accepted handshake.
module adc_word_serializer
    import adc_readout_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DW-1:0]         word,
    input  logic                  word_avail,
    input  logic                  lane_ready,
    output logic [LANE_W-1:0]     lane_dat,
    output logic                  lane_valid,
    output logic [LANE_IDX_W-1:0] lane_idx,
    output logic                  lane_fire,
    output logic                  word_done
);

    assign lane_valid = word_avail;
    assign lane_dat   = lane_valid ? word[LANE_W*lane_idx +: LANE_W] : '0;
    assign lane_fire  = lane_valid && lane_ready;
    assign word_done  = lane_fire && (lane_idx == LAST_LANE);

    // Power-of-two lane count: the index wraps to lane 0 on the last lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_idx <= '0;
        end else if (lane_fire) begin
            lane_idx <= lane_idx + LANE_IDX_W'(1);
        end
    end

endmodule

// File: rtl/adc_fill_reader.sv
// Reads header/data/checksum fills from the acquisition FIFO, streams them
// as 32-bit lanes and verifies the XOR checksum.
//
// state | meaning
// IDLE  | waiting for rd_enable and a non-empty FIFO
// HDR   | streaming header word, fields latched on lane 0
// DATA  | streaming data words, burst counter counting down
// CSUM  | streaming checksum word, compared on lane 0
// ABORT | bad header: drain FIFO until empty, no output
module adc_fill_reader
    import adc_readout_pkg::*;
#(
    parameter int unsigned MAX_BURSTS = 2097151
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    adc_fill_reader_if.master     bus,
    input  logic                  rd_enable,
    output logic [FILL_NUM_W-1:0] fill_num,
    output logic [TYPE_W-1:0]     fill_type,
    output logic [BURSTS_W-1:0]   num_fill_bursts,
    output logic                  fill_done,
    output logic                  csum_err,
    output logic                  fmt_err,
    output logic [CNT_W-1:0]      fills_read,
    output logic [CNT_W-1:0]      csum_err_cnt
);

    logic [ST_W-1:0]       state;
    logic [LANE_W-1:0]     run_xor;
    logic [BURSTS_W-1:0]   rem_bursts;
    logic [LANE_W-1:0]     lane_dat;
    logic                  lane_valid;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic                  lane_fire;
    logic                  word_done;
    logic                  word_avail;
    logic                  hdr_bad;

    // An oversized header is rejected before any of its lanes go out.
    assign hdr_bad = (state == ST_HDR) && !bus.fifo_empty &&
                     (32'(bus.fifo_dout[BURSTS_LSB +: BURSTS_W]) > MAX_BURSTS);

    assign word_avail = !bus.fifo_empty &&
                        ((state == ST_DATA) || (state == ST_CSUM) ||
                         ((state == ST_HDR) && !hdr_bad));

    adc_word_serializer u_ser (
        .clk        (clk),
        .reset_n    (reset_n),
        .word       (bus.fifo_dout),
        .word_avail (word_avail),
        .lane_ready (bus.out_ready),
        .lane_dat   (lane_dat),
        .lane_valid (lane_valid),
        .lane_idx   (lane_idx),
        .lane_fire  (lane_fire),
        .word_done  (word_done)
    );

    assign bus.out_dat    = lane_dat;
    assign bus.out_valid  = lane_valid;
    assign bus.out_last   = lane_valid && (state == ST_CSUM) && (lane_idx == LAST_LANE);
    assign bus.fifo_rd_en = word_done || ((state == ST_ABORT) && !bus.fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            run_xor         <= '0;
            rem_bursts      <= '0;
            fill_num        <= '0;
            fill_type       <= '0;
            num_fill_bursts <= '0;
            fill_done       <= 1'b0;
            csum_err        <= 1'b0;
            fmt_err         <= 1'b0;
            fills_read      <= '0;
            csum_err_cnt    <= '0;
        end else begin
            fill_done <= 1'b0;
            csum_err  <= 1'b0;
            fmt_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_enable && !bus.fifo_empty) begin
                        state   <= ST_HDR;
                        run_xor <= '0;
                    end
                end
                ST_HDR: begin
                    if (hdr_bad) begin
                        fmt_err <= 1'b1;
                        state   <= ST_ABORT;
                    end else if (lane_fire) begin
                        run_xor <= run_xor ^ lane_dat;
                        if (lane_idx == '0) begin
                            fill_num        <= bus.fifo_dout[FILL_NUM_LSB +: FILL_NUM_W];
                            fill_type       <= bus.fifo_dout[TYPE_LSB +: TYPE_W];
                            num_fill_bursts <= bus.fifo_dout[BURSTS_LSB +: BURSTS_W];
                            rem_bursts      <= bus.fifo_dout[BURSTS_LSB +: BURSTS_W];
                        end
                        if (word_done) begin
                            state <= (num_fill_bursts != '0) ? ST_DATA : ST_CSUM;
                        end
                    end
                end
                ST_DATA: begin
                    if (lane_fire) begin
                        run_xor <= run_xor ^ lane_dat;
                        if (word_done) begin
                            rem_bursts <= rem_bursts - BURSTS_W'(1);
                            if (rem_bursts == BURSTS_W'(1)) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (lane_fire) begin
                        if ((lane_idx == '0) && (lane_dat != run_xor)) begin
                            csum_err <= 1'b1;
                            if (csum_err_cnt != {CNT_W{1'b1}}) begin
                                csum_err_cnt <= csum_err_cnt + CNT_W'(1);
                            end
                        end
                        if (word_done) begin
                            fill_done  <= 1'b1;
                            fills_read <= fills_read + CNT_W'(1);
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_ABORT: begin
                    if (bus.fifo_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
